// File: rtl/instr_bus_arbiter.sv
// Two-master, one-slave arbiter for the req/gnt/rvalid fetch bus.
// In-order outstanding IDs are tracked in a small FIFO so each response is routed back to the master that issued it.
module instr_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic [6:0]  m0_rdata_intg_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic [6:0]  m1_rdata_intg_o,
    output logic        m1_err_o,

    output logic        s_req_o,
    output logic [31:0] s_addr_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
    input  logic [6:0]  s_rdata_intg_i,
    input  logic        s_err_i,

    output logic        resp_orphan_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Master IDs: 0 = m0, 1 = m1
    logic             id_fifo_q [MAX_OUTSTANDING];
    logic             id_fifo_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             lock_q, lock_d;
    logic             lock_sel_q, lock_sel_d;
    logic             last_q, last_d;
    logic             orphan_q, orphan_d;

    logic full;
    logic sel;
    logic grant;
    logic pop;
    logic head;

    always_comb begin
        full = (count_q == CNT_MAX);

        if (lock_q) begin
            sel = lock_sel_q;
        end else if (m0_req_i && !m1_req_i) begin
            sel = 1'b0;
        end else if (m1_req_i && !m0_req_i) begin
            sel = 1'b1;
        end else begin
            sel = !last_q;
        end

        s_req_o  = !full && (lock_q || m0_req_i || m1_req_i);
        s_addr_o = sel ? m1_addr_i : m0_addr_i;
        grant    = s_req_o && s_gnt_i;
        m0_gnt_o = grant && !sel;
        m1_gnt_o = grant && sel;

        pop  = s_rvalid_i && (count_q != '0);
        head = id_fifo_q[rd_ptr_q];

        m0_rvalid_o     = pop && !head;
        m1_rvalid_o     = pop && head;
        m0_rdata_o      = s_rdata_i;
        m1_rdata_o      = s_rdata_i;
        m0_rdata_intg_o = s_rdata_intg_i;
        m1_rdata_intg_o = s_rdata_intg_i;
        m0_err_o        = s_err_i;
        m1_err_o        = s_err_i;
        resp_orphan_o   = orphan_q;
    end

    always_comb begin
        id_fifo_d  = id_fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        last_d     = last_q;
        orphan_d   = orphan_q;

        // Hold the selection while the slave stalls so s_addr_o cannot change before the grant
        if (grant) begin
            lock_d = 1'b0;
        end else if (s_req_o) begin
            lock_d     = 1'b1;
            lock_sel_d = sel;
        end

        if (grant) begin
            id_fifo_d[wr_ptr_q] = sel;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
            last_d   = sel;
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end

        case ({grant, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (s_rvalid_i && (count_q == '0)) begin
            orphan_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                id_fifo_q[i] <= 1'b0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            last_q     <= 1'b1;
            orphan_q   <= 1'b0;
        end else begin
            id_fifo_q  <= id_fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            last_q     <= last_d;
            orphan_q   <= orphan_d;
        end
    end

endmodule

// File: tb/tb_instr_bus_arbiter.sv
// Directed bench for instr_bus_arbiter: hand-computed grants, routing, back-pressure and orphan handling.
module tb_instr_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m1_req_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic [6:0]  m0_rdata_intg_o, m1_rdata_intg_o;
    logic        s_req_o;
    logic [31:0] s_addr_o;
    logic        s_gnt_i, s_rvalid_i, s_err_i;
    logic [31:0] s_rdata_i;
    logic [6:0]  s_rdata_intg_i;
    logic        resp_orphan_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_bus_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m0_rdata_intg_o(m0_rdata_intg_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .m1_rdata_intg_o(m1_rdata_intg_o), .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_gnt_i(s_gnt_i),
        .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .s_rdata_intg_i(s_rdata_intg_i), .s_err_i(s_err_i),
        .resp_orphan_o(resp_orphan_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req_i = 0; m1_req_i = 0; m0_addr_i = 0; m1_addr_i = 0;
        s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = 0; s_rdata_intg_i = 0; s_err_i = 0;
    endtask

    task automatic pulse_reset();
        rst = 1; cycle(); rst = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        cycle(); cycle();
        rst = 0;
        #1;
        check_val("rst_s_req", 32'(s_req_o), 0);
        check_val("rst_m0_gnt", 32'(m0_gnt_o), 0);
        check_val("rst_m1_rvalid", 32'(m1_rvalid_o), 0);
        check_val("rst_orphan", 32'(resp_orphan_o), 0);
        check_val("rst_count", 32'(dut.count_q), 0);

        // m0 alone, immediate grant, response one cycle later
        m0_req_i = 1; m0_addr_i = 32'h0; s_gnt_i = 1; #1;
        check_val("t1_s_req", 32'(s_req_o), 1);
        check_val("t1_m0_gnt", 32'(m0_gnt_o), 1);
        check_val("t1_m1_gnt", 32'(m1_gnt_o), 0);
        cycle();
        m0_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h13; #1;
        check_val("t1_m0_rvalid", 32'(m0_rvalid_o), 1);
        check_val("t1_m0_rdata", m0_rdata_o, 32'h13);
        check_val("t1_m1_rvalid", 32'(m1_rvalid_o), 0);
        cycle();
        idle_inputs();

        // Both masters request every cycle; grants alternate m0,m1,m0,m1 from reset
        pulse_reset();
        m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'h10; m1_addr_i = 32'h20; s_gnt_i = 1;
        for (int k = 0; k < 4; k++) begin
            s_rvalid_i = (k > 0);
            s_rdata_i  = 32'(k);
            #1;
            check_val($sformatf("t2_m0_gnt_%0d", k), 32'(m0_gnt_o), (k % 2 == 0) ? 1 : 0);
            check_val($sformatf("t2_m1_gnt_%0d", k), 32'(m1_gnt_o), (k % 2 == 1) ? 1 : 0);
            check_val($sformatf("t2_addr_%0d", k), s_addr_o, (k % 2 == 0) ? 32'h10 : 32'h20);
            if (k > 0) begin
                check_val($sformatf("t2_m0_rv_%0d", k), 32'(m0_rvalid_o), (k % 2 == 1) ? 1 : 0);
                check_val($sformatf("t2_m1_rv_%0d", k), 32'(m1_rvalid_o), (k % 2 == 0) ? 1 : 0);
            end
            cycle();
        end
        m0_req_i = 0; m1_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; #1;
        check_val("t2_last_m1_rv", 32'(m1_rvalid_o), 1);
        check_val("t2_last_m0_rv", 32'(m0_rvalid_o), 0);
        cycle();
        idle_inputs(); #1;
        check_val("t2_count", 32'(dut.count_q), 0);

        // m1 stalled three cycles; m0 joins but the address stays locked on m1
        m1_req_i = 1; m1_addr_i = 32'h100;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin m0_req_i = 1; m0_addr_i = 32'h200; end
            #1;
            check_val($sformatf("t3_addr_stall_%0d", k), s_addr_o, 32'h100);
            check_val($sformatf("t3_gnt_stall_%0d", k), 32'({m1_gnt_o, m0_gnt_o}), 0);
            cycle();
        end
        s_gnt_i = 1; #1;
        check_val("t3_m1_gnt", 32'(m1_gnt_o), 1);
        check_val("t3_m0_gnt_n", 32'(m0_gnt_o), 0);
        check_val("t3_addr_gnt", s_addr_o, 32'h100);
        cycle();
        m1_req_i = 0; #1;
        check_val("t3_m0_gnt", 32'(m0_gnt_o), 1);
        check_val("t3_addr_m0", s_addr_o, 32'h200);
        cycle();
        m0_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1; #1;
        check_val("t3_rv_first_m1", 32'(m1_rvalid_o), 1);
        cycle(); #1;
        check_val("t3_rv_second_m0", 32'(m0_rvalid_o), 1);
        cycle();
        idle_inputs();

        // Back-pressure at MAX_OUTSTANDING=2, no full->grant bypass
        m0_req_i = 1; m0_addr_i = 32'h40; s_gnt_i = 1;
        cycle(); cycle(); #1;
        check_val("t4_full_s_req", 32'(s_req_o), 0);
        check_val("t4_full_gnt", 32'(m0_gnt_o), 0);
        cycle();
        s_rvalid_i = 1; #1;
        check_val("t4_pop_rv", 32'(m0_rvalid_o), 1);
        check_val("t4_no_bypass", 32'(m0_gnt_o), 0);
        cycle();
        s_rvalid_i = 0; #1;
        check_val("t4_gnt_after", 32'(m0_gnt_o), 1);
        cycle();
        m0_req_i = 0; s_gnt_i = 0; s_rvalid_i = 1;
        cycle(); cycle();
        idle_inputs(); #1;
        check_val("t4_drained", 32'(dut.count_q), 0);

        // Simultaneous grant and response with count=1
        m1_req_i = 1; s_gnt_i = 1;
        cycle();
        m1_req_i = 0; m0_req_i = 1; s_rvalid_i = 1; #1;
        check_val("t5_m0_gnt", 32'(m0_gnt_o), 1);
        check_val("t5_m1_rv_old", 32'(m1_rvalid_o), 1);
        check_val("t5_m0_rv_n", 32'(m0_rvalid_o), 0);
        cycle();
        m0_req_i = 0; s_gnt_i = 0; s_rvalid_i = 0; #1;
        check_val("t5_count", 32'(dut.count_q), 1);
        s_rvalid_i = 1; #1;
        check_val("t5_m0_rv", 32'(m0_rvalid_o), 1);
        cycle();
        idle_inputs();

        // Orphan response, sticky until reset
        s_rvalid_i = 1; #1;
        check_val("t6_orph_rv", 32'({m1_rvalid_o, m0_rvalid_o}), 0);
        cycle();
        s_rvalid_i = 0;
        cycle(); #1;
        check_val("t6_orphan_sticky", 32'(resp_orphan_o), 1);
        pulse_reset(); #1;
        check_val("t6_orphan_clr", 32'(resp_orphan_o), 0);
        check_val("t6_count_clr", 32'(dut.count_q), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
